// File: rtl/hex_product_display.sv
// hex_product_display
// Captures a 16-bit multiplier product (optionally two's complement) and
// time-multiplexes it onto a 4-digit common-anode seven-segment display.
// Signed negatives are shown as magnitude with the dp of digit 3 lit.
// Leading zero digits can be blanked. Grid and segment outputs are registered.

module hex_product_display #(
  parameter int REFRESH_BITS = 16,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        load,
  input  logic [15:0] prod_in,
  input  logic        signed_en,
  output logic [3:0]  hex_grid,
  output logic [7:0]  hex_seg
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

  logic [15:0]             r_value;
  logic                    r_neg;
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [1:0]              r_idx;
  logic [3:0]              r_grid;
  logic [7:0]              r_seg;

  logic                    w_wrap;
  logic                    w_cap_neg;
  logic [15:0]             w_cap_value;
  logic [3:0]              w_nibble;
  logic                    w_upper_zero;
  logic [6:0]              w_font;
  logic [3:0]              w_grid_nxt;
  logic [7:0]              w_seg_nxt;

  // Standard active-low hex font, segments g..a, dp handled separately.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // The scan advances on the cycle the refresh counter is all-ones.
  assign w_wrap = &r_cnt;

  // A negative signed word is stored as its magnitude; 0x8000 stays 0x8000.
  assign w_cap_neg   = signed_en & prod_in[15];
  assign w_cap_value = w_cap_neg ? (~prod_in + 16'd1) : prod_in;

  // Capture state, refresh counter and digit index. Loads never disturb the scan.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_value <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_cnt <= r_cnt + CNT_ONE;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      if (load) begin
        r_value <= w_cap_value;
        r_neg   <= w_cap_neg;
      end
    end
  end

  // Select the current digit's nibble and whether everything above it is zero.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    w_nibble     = r_value[3:0];
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd1: begin
        w_nibble     = r_value[7:4];
        w_upper_zero = (r_value[15:4] == 12'd0);
      end
      2'd2: begin
        w_nibble     = r_value[11:8];
        w_upper_zero = (r_value[15:8] == 8'd0);
      end
      2'd3: begin
        w_nibble     = r_value[15:12];
        w_upper_zero = (r_value[15:12] == 4'd0);
      end
      default: begin
        w_nibble     = r_value[3:0];
        w_upper_zero = 1'b0;
      end
    endcase
  end

  assign w_font     = hex_font(w_nibble);
  assign w_grid_nxt = ~(4'b0001 << r_idx);
  // dp of digit 3 marks a negative value, even when the digit itself is blanked.
  assign w_seg_nxt  = {~((r_idx == 2'd3) & r_neg),
                       (BLANK_LZ && w_upper_zero) ? 7'h7F : w_font};

  // Register the display outputs so they are glitch-free at the pins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_grid <= 4'b1110;
      r_seg  <= 8'hC0;
    end else begin
      r_grid <= w_grid_nxt;
      r_seg  <= w_seg_nxt;
    end
  end

  assign hex_grid = r_grid;
  assign hex_seg  = r_seg;

endmodule

// File: tb/tb_hex_product_display.sv
// Testbench for hex_product_display with REFRESH_BITS=2.
// Two instances (leading-zero blanking on and off) share one stimulus stream.
// The driver pushes the expected display per cycle into a queue; a monitor
// pops one entry after every rising edge and compares both instances.

module tb_hex_product_display;

  localparam int R = 2;

  typedef struct packed {
    logic [3:0] grid;
    logic [7:0] seg_b;
    logic [7:0] seg_nb;
  } exp_t;

  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        Clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        Reset_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] prod_in = 16'h0;
  logic        signed_en = 1'b0;
  logic [3:0]  grid_b, grid_nb;
  logic [7:0]  seg_b, seg_nb;

  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;
  exp_t sb_q[$];

  // Reference state: captured value, sign flag and edges since reset release.
  logic [15:0] m_val = 16'h0;
  bit          m_neg = 1'b0;
  int          m_t = 0;

  hex_product_display #(.REFRESH_BITS(R), .BLANK_LZ(1'b1)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .prod_in(prod_in),
    .signed_en(signed_en), .hex_grid(grid_b), .hex_seg(seg_b)
  );

  hex_product_display #(.REFRESH_BITS(R), .BLANK_LZ(1'b0)) u_dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .prod_in(prod_in),
    .signed_en(signed_en), .hex_grid(grid_nb), .hex_seg(seg_nb)
  );

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got grid/seg %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment pattern a viewer should see for digit d of a stored value.
  function automatic logic [7:0] render(input logic [15:0] v, input bit n, input int d, input bit blank);
    logic [15:0] upper;
    logic [6:0]  s;
    upper = v >> (4 * d);
    s = FONT[int'(upper & 16'hF)][6:0];
    if (blank && d > 0 && upper == 16'h0) s = 7'h7F;
    return {~(d == 3 && n), s};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   d;
    d = (m_t / (1 << R)) % 4;
    e.grid   = 4'hF ^ 4'(1 << d);
    e.seg_b  = render(m_val, m_neg, d, 1'b1);
    e.seg_nb = render(m_val, m_neg, d, 1'b0);
    return e;
  endfunction

  // One clock of stimulus applied at the falling edge.
  task automatic cycle(input bit rst, input bit ld, input logic [15:0] p, input bit s);
    @(negedge Clk);
    load = ld; prod_in = p; signed_en = s;
    if (rst) begin
      Reset_n = 1'b0;
      m_val = 16'h0; m_neg = 1'b0; m_t = 0;
      #1;
      check("async_reset_blank", {grid_b, seg_b}, {4'b1110, 8'hC0});
      check("async_reset_noblank", {grid_nb, seg_nb}, {4'b1110, 8'hC0});
      sb_q.push_back(expect_now());
    end else begin
      Reset_n = 1'b1;
      sb_q.push_back(expect_now());
      if (ld) begin
        m_neg = s && p[15];
        m_val = m_neg ? 16'(17'h10000 - 17'(p)) : p;
      end
      m_t++;
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: one scoreboard entry is consumed after every rising edge.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: no expected entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("scan_blank", {grid_b, seg_b}, {e.grid, e.seg_b});
        check("scan_noblank", {grid_nb, seg_nb}, {e.grid, e.seg_nb});
      end
    end
  end

  initial begin
    logic [15:0] p;
    // Reset with no clock running: outputs must settle immediately.
    #5 Reset_n = 1'b0;
    #1;
    check("reset_noclk_blank", {grid_b, seg_b}, {4'b1110, 8'hC0});
    check("reset_noclk_noblank", {grid_nb, seg_nb}, {4'b1110, 8'hC0});
    clk_en = 1'b1;

    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);   // load during reset is discarded
    idle(10);

    cycle(1'b0, 1'b1, 16'h1234, 1'b0);   idle(20);
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b1);   idle(17);
    cycle(1'b0, 1'b1, 16'h8000, 1'b1);   idle(16);
    cycle(1'b0, 1'b1, 16'h8000, 1'b0);   idle(16);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);   idle(16);

    // Load on the edge where the digit index advances.
    while (((m_t + 1) % (1 << R)) != 0) idle(1);
    cycle(1'b0, 1'b1, 16'hABCD, 1'b0);   idle(6);
    // Mid-scan reset, then confirm the captured value reads back as zero.
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    idle(18);

    // Back-to-back loads: the last one wins.
    cycle(1'b0, 1'b1, 16'h1111, 1'b0);
    cycle(1'b0, 1'b1, 16'hF00D, 1'b1);
    idle(16);

    // Randomized traffic, biased toward small values to exercise blanking.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 16'($urandom_range(0, 255));
        1:       p = 16'hFF00 | 16'($urandom_range(0, 255));
        default: p = 16'($urandom);
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, p, 1'($urandom_range(0, 1)));
    end
    idle(2);

    @(posedge Clk);
    #2;
    check("sb_drain", 12'(sb_q.size()), 12'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_product_display.md
HEX_PRODUCT_DISPLAY -- requirements
Module: hex_product_display

Interface
REQ-001 The module SHALL have parameter REFRESH_BITS, default 16, meaning the digit scan advances every 2^REFRESH_BITS clock cycles.
REQ-002 The module SHALL have parameter BLANK_LZ, default 1, meaning leading-zero digits are blanked when set to 1.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port load, input, 1 bit: when high at a rising edge, prod_in and signed_en are captured.
REQ-006 The module SHALL have port prod_in, input, 16 bits: the product word {A,B} from the multiplier.
REQ-007 The module SHALL have port signed_en, input, 1 bit: when high, prod_in is treated as two's complement.
REQ-008 The module SHALL have port hex_grid, output, 4 bits: active-low one-hot digit enable; bit 0 is the rightmost digit.
REQ-009 The module SHALL have port hex_seg, output, 8 bits: active-low segments with bit 7 = dp and bits 6:0 = g,f,e,d,c,b,a.

Function
REQ-010 On load, the block SHALL capture value = prod_in and neg = 0 when signed_en=0 or prod_in[15]=0.
REQ-011 On load with signed_en=1 and prod_in[15]=1, the block SHALL capture value = (~prod_in + 1) mod 2^16 and neg = 1; 0x8000 captures as value 0x8000 with neg=1.
REQ-012 When load is low, the block SHALL hold value and neg indefinitely.
REQ-013 A free-running REFRESH_BITS-wide counter SHALL wrap from all-ones to 0; on each wrap, the digit index (2 bits) SHALL advance 0->1->2->3->0.
REQ-014 Digit d SHALL display value[4d+3:4d] using the standard hex font (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, with dp off).
REQ-015 With BLANK_LZ=1, digit d>0 SHALL be blanked (segments 6:0 all 1) when value[15:4d] == 0; digit 0 SHALL never be blanked.
REQ-016 hex_seg[7] SHALL be 0 only when the index is 3 and neg=1, and this SHALL hold even if digit 3 is blanked.
REQ-017 hex_grid SHALL stay asserted for the current index during blanked digits, with exactly one bit low at all times.
REQ-018 hex_grid and hex_seg SHALL be registered outputs; a load or index change at edge N SHALL be reflected at the outputs after edge N+1.
REQ-019 When load and an index advance occur at the same edge, both SHALL take effect, and the outputs at N+1 SHALL show the new digit of the new value.
REQ-020 A load SHALL NOT reset the refresh counter or the digit index.
REQ-021 The block SHALL have no backpressure: every load is accepted, and back-to-back loads keep the last value.

Reset
REQ-022 While Reset_n=0, asynchronously and without waiting for Clk, value=0, neg=0, counter=0, index=0, hex_grid=4'b1110 and hex_seg=8'hC0.
REQ-023 Operation SHALL resume at the first rising edge after Reset_n deasserts, with index 0 held for a full 2^REFRESH_BITS cycles.
REQ-024 Reset asserted mid-scan or coincident with load SHALL take priority; the load is discarded.

Verification (REFRESH_BITS=2, BLANK_LZ=1 unless stated)
REQ-025 Reset: Reset_n low, no clock -> hex_grid=1110 and hex_seg=C0 immediately; after release, these hold for 4 cycles and then grid=1101 and seg=FF.
REQ-026 Unsigned load: load prod_in=0x1234 with signed_en=0 -> the scan shows grid 1110/99, 1101/B0, 1011/A4, 0111/F9, and then repeats.
REQ-027 Signed negative: load 0xFFFE with signed_en=1 -> digit0=A4, digit1=FF, digit2=FF, digit3=7F.
REQ-028 Signed boundary: load 0x8000 with signed_en=1 -> digit0..2=C0, digit3=00 (8 with dp on); with signed_en=0 the same word gives digit3=80.
REQ-029 Zero with blanking: load 0x0000 -> digit0=C0 and digits1-3=FF; with BLANK_LZ=0 all four digits show C0.
REQ-030 Collision/reset: load 0xABCD at the index-advance edge -> the next digit shows the new value's digit one cycle later; then assert Reset_n low mid-scan -> outputs show 1110/C0 at once, and the captured value reads 0 after release.
